pmem_arbiter: RTL and testbench
===============================

// Module: pmem_arbiter
// PURPOSE
//  Shares one physical-memory port (256-bit line interface) between the instruction-side
//  cache hierarchy (IF stage pmem_i*) and the data-side cache hierarchy (MEM stage pmem_d*).
//  Sits between the last-level I/D caches and main memory; grants one whole line transaction
//  at a time, with fixed priority plus an anti-starvation counter.
// PARAMETERS
//  D_PRIORITY   1'b1  1: data side wins simultaneous requests; 0: instruction side wins
//  MAX_CONSEC   4     max back-to-back grants to the priority side while the other side waits (>=1)
// PORTS
//  clk            in   1    clock, all state on rising edge
//  rst            in   1    synchronous, active-high reset
//  pmem_iread     in   1    I-side line read request (held until pmem_iresp)
//  pmem_iwrite    in   1    I-side line write request (tie 0 normally; still arbitrated)
//  pmem_iaddress  in   32   I-side line address (bits[4:0] ignored, forwarded as given)
//  pmem_iwdata    in   256  I-side write line
//  pmem_iresp     out  1    I-side completion, one cycle
//  pmem_irdata    out  256  I-side read line, valid while pmem_iresp=1
//  pmem_dread     in   1    D-side line read request
//  pmem_dwrite    in   1    D-side line write request (writeback)
//  pmem_daddress  in   32   D-side line address
//  pmem_dwdata    in   256  D-side write line
//  pmem_dresp     out  1    D-side completion, one cycle
//  pmem_drdata    out  256  D-side read line, valid while pmem_dresp=1
//  pmem_read      out  1    to memory: read request
//  pmem_write     out  1    to memory: write request
//  pmem_address   out  32   to memory: address
//  pmem_wdata     out  256  to memory: write line
//  pmem_resp      in   1    from memory: transaction done
//  pmem_rdata     in   256  from memory: read line
// BEHAVIOUR
//  - FSM states: IDLE, SERVE_I, SERVE_D, DONE. Reset -> IDLE, consec counter 0, all
//    memory-side outputs 0, pmem_iresp=pmem_dresp=0.
//  - IDLE: req_i = iread|iwrite, req_d = dread|dwrite. Neither -> stay. One -> grant it.
//    Both -> grant priority side, unless consec==MAX_CONSEC -> grant the other side.
//  - On grant (IDLE->SERVE_x at edge t): latch read, write, address, wdata of winner into
//    output regs; pmem_read/pmem_write visible from cycle t+1, held constant until pmem_resp.
//    Requester inputs are not re-sampled during SERVE_x.
//  - SERVE_x: pmem_resp=1 -> pmem_xresp=1 combinationally in that same cycle,
//    pmem_xrdata=pmem_rdata; clear pmem_read/pmem_write at that edge; -> DONE.
//    Non-granted side: resp always 0; rdata drives 0.
//  - DONE: one dead cycle so the requester can drop its request; -> IDLE. Minimum
//    request-to-next-grant gap is therefore 1 cycle after resp; no back-to-back grant in
//    the resp cycle.
//  - consec: +1 (saturating at MAX_CONSEC) when priority side granted while other side
//    requesting; cleared when the non-priority side is granted, or when the priority side
//    is granted with the other side idle.
//  - Both read and write asserted by one requester: forward both; memory behaviour undefined
//    (protocol violation, assertion in bench).
//  - pmem_resp outside SERVE_x: ignored, no resp forwarded.
//  - Requester drops request mid-SERVE: ignored; transaction completes, resp still pulsed.
//  - rst during SERVE_x: abort immediately to IDLE, outputs cleared next edge; memory model
//    must also be reset.
// STRUCTURE
//  - Shared package rv32i_types: typedef enum pmem_arb_state_t {ARB_IDLE, ARB_SERVE_I,
//    ARB_SERVE_D, ARB_DONE}; typedef enum {ARB_I, ARB_D} arb_src_t; localparam line width 256.
//  - Single module, no sub-module: one state register block, one latch block for the memory-
//    side request, combinational resp/rdata demux. consec width $clog2(MAX_CONSEC+1).
// TESTING
//  1. I-read only, addr 0x0000_0060, mem resp after 5 cycles with 256'hA5..A5 ->
//     pmem_read=1 from cycle 1 to resp, pmem_iresp one pulse with that line, pmem_dresp=0.
//  2. I-read and D-write(0x0000_1000) raised same cycle, D_PRIORITY=1 -> D write served first,
//     pmem_write=1 and pmem_address=0x1000; after DONE, I-read granted.
//  3. D and I both requesting continuously, MAX_CONSEC=4 -> grant order D,D,D,D,I,D,D,D,D,I,...
//  4. Change pmem_daddress mid-SERVE_D -> pmem_address unchanged until resp.
//  5. Stray pmem_resp in IDLE -> no iresp/dresp pulse, state stays IDLE.
//  6. rst asserted 2 cycles into SERVE_I -> next cycle pmem_read=0, state IDLE, consec=0;
//     fresh request after rst served normally.

Source files
------------

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter.
//   LINE_W / ADDR_W  : line and address widths of the pmem interface
//   pmem_arb_state_t : arbiter FSM states
//   arb_src_t        : which requester owns the memory port
package pmem_arbiter_pkg;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D,
    ARB_DONE
  } pmem_arb_state_t;

  typedef enum logic {
    ARB_I,
    ARB_D
  } arb_src_t;

endpackage

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one 256-bit line memory port between the I-side and
// D-side cache hierarchies. One whole line transaction is granted at a time
// with fixed priority, bounded by an anti-starvation counter.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   pmem_i{read,write,address,wdata} I-side request (held until pmem_iresp)
//   pmem_iresp, pmem_irdata          I-side one-cycle completion + read line
//   pmem_d{read,write,address,wdata} D-side request (held until pmem_dresp)
//   pmem_dresp, pmem_drdata          D-side one-cycle completion + read line
//   pmem_{read,write,address,wdata}  registered request towards memory
//   pmem_resp, pmem_rdata            memory completion + read line
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter logic D_PRIORITY = 1'b1,
  parameter int   MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_iread,
  input  logic              pmem_iwrite,
  input  logic [ADDR_W-1:0] pmem_iaddress,
  input  logic [LINE_W-1:0] pmem_iwdata,
  output logic              pmem_iresp,
  output logic [LINE_W-1:0] pmem_irdata,
  input  logic              pmem_dread,
  input  logic              pmem_dwrite,
  input  logic [ADDR_W-1:0] pmem_daddress,
  input  logic [LINE_W-1:0] pmem_dwdata,
  output logic              pmem_dresp,
  output logic [LINE_W-1:0] pmem_drdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  localparam int               CNT_W   = $clog2(MAX_CONSEC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CONSEC);

  pmem_arb_state_t   r_state;
  logic [CNT_W-1:0]  r_consec;
  logic              r_read;
  logic              r_write;
  logic [ADDR_W-1:0] r_address;
  logic [LINE_W-1:0] r_wdata;

  logic     w_req_i;
  logic     w_req_d;
  logic     w_req_pri;
  logic     w_req_oth;
  logic     w_grant;
  logic     w_serve_i;
  logic     w_serve_d;
  arb_src_t w_pri_src;
  arb_src_t w_oth_src;
  arb_src_t w_win;

  assign w_req_i   = pmem_iread | pmem_iwrite;
  assign w_req_d   = pmem_dread | pmem_dwrite;
  assign w_pri_src = D_PRIORITY ? ARB_D : ARB_I;
  assign w_oth_src = D_PRIORITY ? ARB_I : ARB_D;
  assign w_req_pri = D_PRIORITY ? w_req_d : w_req_i;
  assign w_req_oth = D_PRIORITY ? w_req_i : w_req_d;
  assign w_grant   = (r_state == ARB_IDLE) && (w_req_i || w_req_d);

  // Priority side wins a tie unless it has already taken MAX_CONSEC grants
  // in a row while the other side was kept waiting.
  always_comb begin
    w_win = w_pri_src;
    if (w_req_pri && w_req_oth) begin
      w_win = (r_consec == CNT_MAX) ? w_oth_src : w_pri_src;
    end else if (w_req_oth) begin
      w_win = w_oth_src;
    end
  end

  // State register and anti-starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ARB_IDLE;
      r_consec <= '0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_grant) begin
            r_state <= (w_win == ARB_D) ? ARB_SERVE_D : ARB_SERVE_I;
            if (w_win == w_pri_src && w_req_oth) begin
              if (r_consec != CNT_MAX) r_consec <= r_consec + 1'b1;
            end else begin
              r_consec <= '0;
            end
          end
        end
        ARB_SERVE_I, ARB_SERVE_D: begin
          if (pmem_resp) r_state <= ARB_DONE;
        end
        // Dead cycle: lets the requester drop its request before re-arbitration.
        ARB_DONE: r_state <= ARB_IDLE;
        default:  r_state <= ARB_IDLE;
      endcase
    end
  end

  // Memory-side request latch: captured once at grant, held until pmem_resp.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_address <= '0;
      r_wdata   <= '0;
    end else if (w_grant) begin
      if (w_win == ARB_D) begin
        r_read    <= pmem_dread;
        r_write   <= pmem_dwrite;
        r_address <= pmem_daddress;
        r_wdata   <= pmem_dwdata;
      end else begin
        r_read    <= pmem_iread;
        r_write   <= pmem_iwrite;
        r_address <= pmem_iaddress;
        r_wdata   <= pmem_iwdata;
      end
    end else if ((r_state == ARB_SERVE_I || r_state == ARB_SERVE_D) && pmem_resp) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
    end
  end

  assign pmem_read    = r_read;
  assign pmem_write   = r_write;
  assign pmem_address = r_address;
  assign pmem_wdata   = r_wdata;

  // Completion demux: memory resp is forwarded only to the side being served;
  // a resp seen in IDLE/DONE is dropped.
  assign w_serve_i   = (r_state == ARB_SERVE_I);
  assign w_serve_d   = (r_state == ARB_SERVE_D);
  assign pmem_iresp  = w_serve_i & pmem_resp;
  assign pmem_dresp  = w_serve_d & pmem_resp;
  assign pmem_irdata = w_serve_i ? pmem_rdata : '0;
  assign pmem_drdata = w_serve_d ? pmem_rdata : '0;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: requesters push expected completions,
// a negedge monitor pops/compares them and checks each grant against a
// rule-level arbitration model. A behavioural line memory answers requests.
module tb_pmem_arbiter;

  localparam logic D_PRI = 1'b1;
  localparam int   MAXC  = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         pmem_iread, pmem_iwrite, pmem_dread, pmem_dwrite;
  logic [31:0]  pmem_iaddress, pmem_daddress, pmem_address;
  logic [255:0] pmem_iwdata, pmem_dwdata, pmem_irdata, pmem_drdata;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_iresp, pmem_dresp, pmem_read, pmem_write, pmem_resp;

  pmem_arbiter #(.D_PRIORITY(D_PRI), .MAX_CONSEC(MAXC)) dut (
    .clk(clk), .rst(rst),
    .pmem_iread(pmem_iread), .pmem_iwrite(pmem_iwrite),
    .pmem_iaddress(pmem_iaddress), .pmem_iwdata(pmem_iwdata),
    .pmem_iresp(pmem_iresp), .pmem_irdata(pmem_irdata),
    .pmem_dread(pmem_dread), .pmem_dwrite(pmem_dwrite),
    .pmem_daddress(pmem_daddress), .pmem_dwdata(pmem_dwdata),
    .pmem_dresp(pmem_dresp), .pmem_drdata(pmem_drdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [255:0] dflt(input logic [31:0] a);
    return {8{a ^ 32'h3C5A_0F69}};
  endfunction

  logic [255:0] mem     [logic [31:0]];   // contents held by the memory model
  logic [255:0] ref_mem [logic [31:0]];   // contents predicted at issue time
  logic [256:0] exp_i[$], exp_d[$];       // {is_read, expected line}
  logic [31:0]  grant_log[$];
  int           fixed_lat = 0;
  bit           stray_req = 1'b0;

  // Behavioural line memory: latency counted from the first cycle a request
  // is visible; idle request lines abort any pending access (covers reset).
  initial begin : memmodel
    int cnt;
    bit busy;
    cnt = 0; busy = 1'b0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      pmem_resp = 1'b0; pmem_rdata = '0;
      if (stray_req) begin
        pmem_resp = 1'b1; pmem_rdata = {8{32'hDEAD_BEEF}}; stray_req = 1'b0;
      end else if (!(pmem_read || pmem_write)) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = (fixed_lat != 0) ? fixed_lat - 1 : int'($urandom_range(0, 5));
        end else begin
          cnt--;
        end
        if (cnt == 0) begin
          pmem_resp = 1'b1;
          if (pmem_write) mem[pmem_address] = pmem_wdata;
          else pmem_rdata = mem.exists(pmem_address) ? mem[pmem_address] : dflt(pmem_address);
          busy = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard pops on completions, arbitration model on grants.
  initial begin : monitor
    bit           prev_act, resp_prev, act, ri, rq, pri_r, oth_r, win;
    int           mcnt;
    logic [256:0] e;
    logic         s_ird, s_iwr, s_drd, s_dwr, l_rd, l_wr;
    logic [31:0]  s_iad, s_dad, l_ad;
    logic [255:0] s_iwd, s_dwd, l_wd;
    prev_act = 0; resp_prev = 0; mcnt = 0;
    s_ird = 0; s_iwr = 0; s_drd = 0; s_dwr = 0; s_iad = 0; s_dad = 0; s_iwd = 0; s_dwd = 0;
    l_rd = 0; l_wr = 0; l_ad = 0; l_wd = 0;
    forever begin
      @(negedge clk);
      assert (!(pmem_iread && pmem_iwrite) && !(pmem_dread && pmem_dwrite))
        else $error("requester asserted read and write together");
      if (rst) begin
        exp_i.delete(); exp_d.delete();
        mcnt = 0; prev_act = 0; resp_prev = 0;
      end else begin
        act = pmem_read | pmem_write;
        if (resp_prev) chk("req_cleared_after_resp", act, 0);
        if (act && !prev_act) begin
          ri    = s_ird | s_iwr;
          rq    = s_drd | s_dwr;
          pri_r = D_PRI ? rq : ri;
          oth_r = D_PRI ? ri : rq;
          chk("grant_without_request", ri | rq, 1);
          if (pri_r && oth_r) win = (mcnt == MAXC) ? !D_PRI : D_PRI;
          else                win = rq;
          if (win == D_PRI) mcnt = oth_r ? ((mcnt < MAXC) ? mcnt + 1 : MAXC) : 0;
          else              mcnt = 0;
          chk("grant_addr",  pmem_address, win ? s_dad : s_iad);
          chk("grant_read",  pmem_read,    win ? s_drd : s_ird);
          chk("grant_write", pmem_write,   win ? s_dwr : s_iwr);
          chk("grant_wdata", pmem_wdata,   win ? s_dwd : s_iwd);
          l_rd = pmem_read; l_wr = pmem_write; l_ad = pmem_address; l_wd = pmem_wdata;
          grant_log.push_back(pmem_address);
        end else if (act) begin
          chk("hold_addr",  pmem_address, l_ad);
          chk("hold_read",  pmem_read,    l_rd);
          chk("hold_write", pmem_write,   l_wr);
          chk("hold_wdata", pmem_wdata,   l_wd);
        end
        if (pmem_resp && !act) begin
          chk("stray_iresp", pmem_iresp, 0);
          chk("stray_dresp", pmem_dresp, 0);
        end
        if (pmem_iresp) begin
          chk("iresp_with_dresp", pmem_dresp, 0);
          chk("drdata_zero_on_iresp", pmem_drdata, 0);
          if (exp_i.size() == 0) chk("iresp_unexpected", pmem_iresp, 0);
          else begin
            e = exp_i.pop_front();
            if (e[256]) chk("irdata", pmem_irdata, e[255:0]);
          end
        end
        if (pmem_dresp) begin
          chk("irdata_zero_on_dresp", pmem_irdata, 0);
          if (exp_d.size() == 0) chk("dresp_unexpected", pmem_dresp, 0);
          else begin
            e = exp_d.pop_front();
            if (e[256]) chk("drdata", pmem_drdata, e[255:0]);
          end
        end
        resp_prev = act && pmem_resp;
        prev_act  = act;
      end
      s_ird = pmem_iread; s_iwr = pmem_iwrite; s_iad = pmem_iaddress; s_iwd = pmem_iwdata;
      s_drd = pmem_dread; s_dwr = pmem_dwrite; s_dad = pmem_daddress; s_dwd = pmem_dwdata;
    end
  end

  task automatic clear_side(input bit side_d);
    if (side_d) begin pmem_dread = 0; pmem_dwrite = 0; end
    else        begin pmem_iread = 0; pmem_iwrite = 0; end
  endtask

  // Issue one transaction (called at posedge+1), push its expectation, wait
  // for completion, and optionally keep the request lines up for the next one.
  task automatic do_txn(input bit side_d, input bit rd, input logic [31:0] a,
                        input logic [255:0] wd, input bit keep);
    logic [255:0] e;
    bit got;
    e = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    if (!rd) ref_mem[a] = wd;
    if (side_d) begin
      exp_d.push_back({rd, e});
      pmem_dread = rd; pmem_dwrite = !rd; pmem_daddress = a; pmem_dwdata = wd;
    end else begin
      exp_i.push_back({rd, e});
      pmem_iread = rd; pmem_iwrite = !rd; pmem_iaddress = a; pmem_iwdata = wd;
    end
    got = 0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      got = side_d ? pmem_dresp : pmem_iresp;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_resp_timeout actual=none required=pulse", side_d ? "d" : "i");
    end
    @(posedge clk); #1;
    if (!keep) clear_side(side_d);
  endtask

  function automatic logic [255:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin : main
    bit          pat [10];
    bit          seen;
    int          n;
    logic [31:0] a;
    fork
      begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
      end
    join_none

    rst = 1; pmem_iread = 0; pmem_iwrite = 0; pmem_dread = 0; pmem_dwrite = 0;
    pmem_iaddress = 0; pmem_daddress = 0; pmem_iwdata = 0; pmem_dwdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read",    pmem_read, 0);
    chk("rst_write",   pmem_write, 0);
    chk("rst_address", pmem_address, 0);
    chk("rst_iresp",   pmem_iresp, 0);
    chk("rst_dresp",   pmem_dresp, 0);
    @(posedge clk); #1; rst = 0;

    // I-read only, fixed 5-cycle memory latency
    mem[32'h60] = {32{8'hA5}}; ref_mem[32'h60] = {32{8'hA5}};
    fixed_lat = 5;
    fork
      do_txn(0, 1, 32'h0000_0060, '0, 0);
      begin
        n = 0; seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
          @(negedge clk);
          if (pmem_read) n++;
          seen = pmem_iresp;
        end
        chk("t1_read_cycles", n, 5);
      end
    join
    fixed_lat = 0;

    // Stray memory resp while idle
    @(posedge clk); #1; stray_req = 1; seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (pmem_resp) begin
        seen = 1;
        chk("t5_no_iresp", pmem_iresp, 0);
        chk("t5_no_dresp", pmem_dresp, 0);
      end
    end
    chk("t5_still_idle", pmem_read | pmem_write, 0);
    @(posedge clk); #1;

    // Simultaneous I-read and D-write: D first
    grant_log.delete();
    fork
      do_txn(1, 0, 32'h0000_1000, rnd_line(), 0);
      do_txn(0, 1, 32'h0000_0080, '0, 0);
    join
    chk("t2_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t2_first_addr",  grant_log[0], 32'h0000_1000);
      chk("t2_second_addr", grant_log[1], 32'h0000_0080);
    end

    // Both sides requesting continuously: D,D,D,D,I,D,D,D,D,I
    grant_log.delete();
    fork
      for (int k = 0; k < 8; k++) do_txn(1, 1, 32'h8000_0000 + 32'(k * 32), '0, k < 7);
      for (int k = 0; k < 2; k++) do_txn(0, 1, 32'h0000_0100 + 32'(k * 32), '0, k < 1);
    join
    pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    chk("t3_grants", grant_log.size(), 10);
    for (int k = 0; k < 10; k++)
      if (k < grant_log.size()) chk($sformatf("t3_grant%0d_is_d", k), grant_log[k][31], pat[k]);

    // D address changes mid-serve
    fixed_lat = 6;
    fork
      do_txn(1, 1, 32'h8000_0100, '0, 0);
      begin
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin @(negedge clk); seen = pmem_read; end
        @(posedge clk); #1; @(posedge clk); #1;
        pmem_daddress = 32'h8000_0ABC;
        @(negedge clk);
        chk("t4_addr_held", pmem_address, 32'h8000_0100);
      end
    join
    fixed_lat = 0;

    // Reset two cycles into SERVE_I
    fixed_lat = 20;
    pmem_iread = 1; pmem_iaddress = 32'h0000_0200;
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin @(negedge clk); seen = pmem_read; end
    chk("t6_granted", seen, 1);
    @(posedge clk); #1;
    rst = 1; pmem_iread = 0;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("t6_read_cleared",  pmem_read, 0);
    chk("t6_addr_cleared",  pmem_address, 0);
    chk("t6_no_iresp",      pmem_iresp, 0);
    fixed_lat = 0;
    @(posedge clk); #1;
    do_txn(0, 1, 32'h0000_0200, '0, 0);

    // Randomized traffic on both sides
    fork
      for (int k = 0; k < 25; k++) begin
        int g;
        g = int'($urandom_range(0, 3));
        a = {23'd0, 4'($urandom_range(0, 15)), 5'd0};
        do_txn(0, $urandom_range(0, 7) != 0, a, rnd_line(), g == 0 && k < 24);
        repeat (g) @(posedge clk);
        if (g != 0) #1;
      end
      for (int k = 0; k < 25; k++) begin
        int g;
        g = int'($urandom_range(0, 3));
        a = 32'h8000_0000 | {23'd0, 4'($urandom_range(0, 15)), 5'd0};
        do_txn(1, $urandom_range(0, 1) != 0, a, rnd_line(), g == 0 && k < 24);
        repeat (g) @(posedge clk);
        if (g != 0) #1;
      end
    join
    repeat (4) @(posedge clk);
    chk("exp_i_drained", exp_i.size(), 0);
    chk("exp_d_drained", exp_d.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
